// File: rtl/cache_port_arbiter_if.sv
// Bundle for the two requester ports, the response path, the cache access
// port and the grant counters of cache_port_arbiter.
//   slave  : arbiter view (takes requests, drives cache port and responses)
//   master : requester/cache view (drives requests and cache results)
interface cache_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [ADDR_W-1:0] req0_addr_i;
  logic              req0_we_i;
  logic [DATA_W-1:0] req0_wdata_i;
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [ADDR_W-1:0] req1_addr_i;
  logic              req1_we_i;
  logic [DATA_W-1:0] req1_wdata_i;
  logic              rsp0_valid_o;
  logic              rsp1_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_hit_o;
  logic              c_acc_o;
  logic              c_we_o;
  logic [ADDR_W-1:0] c_addr_o;
  logic [DATA_W-1:0] c_wdata_o;
  logic [DATA_W-1:0] c_rdata_i;
  logic              c_hit_i;
  logic [CNT_W-1:0]  grant0_cnt_o;
  logic [CNT_W-1:0]  grant1_cnt_o;

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_we_i, req0_wdata_i,
    input  req1_valid_i, req1_addr_i, req1_we_i, req1_wdata_i,
    input  c_rdata_i, c_hit_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp1_valid_o, rsp_rdata_o, rsp_hit_o,
    output c_acc_o, c_we_o, c_addr_o, c_wdata_o,
    output grant0_cnt_o, grant1_cnt_o
  );

  modport master (
    output req0_valid_i, req0_addr_i, req0_we_i, req0_wdata_i,
    output req1_valid_i, req1_addr_i, req1_we_i, req1_wdata_i,
    output c_rdata_i, c_hit_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp1_valid_o, rsp_rdata_o, rsp_hit_o,
    input  c_acc_o, c_we_o, c_addr_o, c_wdata_o,
    input  grant0_cnt_o, grant1_cnt_o
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single access
// port of the direct-mapped cache. Port 0 = fetch, port 1 = load/store.
// One request at a time: accept -> one-cycle cache strobe -> wait for the
// cache's registered result -> one-cycle response pulse to the granted port.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : request ports, response path, cache port, grant counters
module cache_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  cache_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              sel_valid, sel_port, accept;
  logic              last_grant_q, gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              hit_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;

  // On a tie the port that did not win last time is selected.
  always_comb begin
    sel_valid = bus.req0_valid_i | bus.req1_valid_i;
    if (bus.req0_valid_i && bus.req1_valid_i) sel_port = ~last_grant_q;
    else                                      sel_port = bus.req1_valid_i;
    accept = (state_q == IDLE) && sel_valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready_o = accept & ~sel_port;
    bus.req1_ready_o = accept & sel_port;
    bus.c_acc_o      = (state_q == ISSUE);
    bus.rsp0_valid_o = (state_q == RESP) & ~gnt_q;
    bus.rsp1_valid_o = (state_q == RESP) & gnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      if (accept) begin
        gnt_q        <= sel_port;
        last_grant_q <= sel_port;
        addr_q       <= sel_port ? bus.req1_addr_i  : bus.req0_addr_i;
        we_q         <= sel_port ? bus.req1_we_i    : bus.req0_we_i;
        wdata_q      <= sel_port ? bus.req1_wdata_i : bus.req0_wdata_i;
        if (sel_port) cnt1_q <= cnt1_q + 1'b1;
        else          cnt0_q <= cnt0_q + 1'b1;
      end
      // Cache output is valid in WAIT; writes return zero data.
      if (state_q == WAIT) begin
        rdata_q <= we_q ? '0 : bus.c_rdata_i;
        hit_q   <= bus.c_hit_i;
      end
    end
  end

  assign bus.c_addr_o     = addr_q;
  assign bus.c_we_o       = we_q;
  assign bus.c_wdata_o    = wdata_q;
  assign bus.rsp_rdata_o  = rdata_q;
  assign bus.rsp_hit_o    = hit_q;
  assign bus.grant0_cnt_o = cnt0_q;
  assign bus.grant1_cnt_o = cnt1_q;

endmodule
